// File: rtl/otter_lsu_pkg.sv
// otter_lsu shared types and constants.
// FSM states, access sizes and IO window base.
package otter_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_HI,
    RD_MERGE,
    WR_BYTES
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [31:0] IO_BASE_DEF = 32'h11000000;

endpackage

// File: rtl/otter_lsu_align.sv
// otter_lsu misaligned read merge.
// Extracts a half/word from two adjacent words.
module otter_lsu_align
  import otter_lsu_pkg::*;
(
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  // shift the 64-bit pair down by the byte offset, then extend halves
  always_comb begin
    sh = 32'({hi_i, lo_i} >> {off_i, 3'b000});
    data_o = sh;
    if (size_i == SZ_HALF) begin
      if (zext_i)
        data_o = {16'h0000, sh[15:0]};
      else
        data_o = {{16{sh[15]}}, sh[15:0]};
    end
  end

endmodule

// File: rtl/otter_lsu.sv
// otter_lsu load/store unit.
// Splits misaligned accesses for the data port.
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [1:0]  SIZE,
  input  logic        SIGN,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        sign_q;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        mis;
  logic        last;
  logic [31:0] base;
  logic [31:0] merged;
  logic [7:0]  wbyte;

  // RST gates acceptance so strobes stay low while reset is held
  assign accept = REQ && (state_q == IDLE) && !RST;
  assign mis = ((SIZE == SZ_HALF && ADDR[1:0] == 2'b11) ||
                (SIZE == SZ_WORD && ADDR[1:0] != 2'b00)) &&
               (ADDR < IO_BASE);
  assign base  = {addr_q[31:2], 2'b00};
  assign last  = (size_q == SZ_HALF) ? (cnt_q == 2'd1)
                                     : (cnt_q == 2'd3);
  assign wbyte = 8'(wdata_q >> {cnt_q, 3'b000});

  otter_lsu_align u_align (
    .lo_i   (lo_q),
    .hi_i   (MEM_DOUT2),
    .off_i  (addr_q[1:0]),
    .size_i (size_q),
    .zext_i (sign_q),
    .data_o (merged)
  );

  assign BUSY  = (state_q != IDLE);
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;

  // next state and memory port drive
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    MEM_ADDR2  = 32'h0;
    MEM_DIN2   = 32'h0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    MEM_SIZE   = SZ_BYTE;
    MEM_SIGN   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (SIZE == SZ_ILL) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (WE) begin
            MEM_WRITE2 = 1'b1;
            MEM_ADDR2  = ADDR;
            MEM_SIGN   = SIGN;
            if (mis) begin
              MEM_SIZE = SZ_BYTE;
              MEM_DIN2 = {24'h0, WDATA[7:0]};
              cnt_d    = 2'd1;
              state_d  = WR_BYTES;
            end else begin
              MEM_SIZE = SIZE;
              MEM_DIN2 = WDATA;
              done_d   = 1'b1;
            end
          end else begin
            MEM_READ2 = 1'b1;
            if (mis) begin
              MEM_ADDR2 = {ADDR[31:2], 2'b00};
              MEM_SIZE  = SZ_WORD;
              state_d   = RD_HI;
            end else begin
              MEM_ADDR2 = ADDR;
              MEM_SIZE  = SIZE;
              MEM_SIGN  = SIGN;
              state_d   = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        rdata_d = MEM_DOUT2;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RD_HI: begin
        lo_d      = MEM_DOUT2;
        MEM_READ2 = 1'b1;
        MEM_ADDR2 = base + 32'd4;
        MEM_SIZE  = SZ_WORD;
        state_d   = RD_MERGE;
      end
      RD_MERGE: begin
        rdata_d = merged;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      WR_BYTES: begin
        MEM_WRITE2 = 1'b1;
        MEM_ADDR2  = addr_q + {30'h0, cnt_q};
        MEM_SIZE   = SZ_BYTE;
        MEM_DIN2   = {24'h0, wbyte};
        if (last) begin
          done_d  = 1'b1;
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, result and progress registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // request capture at acceptance
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= ADDR;
      wdata_q <= WDATA;
      size_q  <= SIZE;
      sign_q  <= SIGN;
    end
  end

endmodule

// File: tb/tb_otter_lsu.sv
// otter_lsu testbench.
// Directed plan steps followed by random traffic.
module tb_otter_lsu;

  localparam logic [31:0] IOB = 32'h11000000;

  logic        CLK = 1'b0;
  logic        RST, REQ, WE, SIGN;
  logic [31:0] ADDR, WDATA, MEM_DOUT2;
  logic [1:0]  SIZE;
  logic        BUSY, DONE, ERR;
  logic [31:0] RDATA, MEM_ADDR2, MEM_DIN2;
  logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
  logic [1:0]  MEM_SIZE;

  otter_lsu dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE),
    .ADDR(ADDR), .WDATA(WDATA), .SIZE(SIZE), .SIGN(SIGN),
    .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_WRITE2(MEM_WRITE2), .MEM_READ2(MEM_READ2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  int npass = 0;
  int ntot  = 0;

  logic [7:0] smem [512];
  logic [7:0] rmem [512];

  int          lg_c [$];
  logic        lg_w [$];
  logic [31:0] lg_a [$];
  logic [31:0] lg_d [$];
  logic [1:0]  lg_s [$];

  logic [31:0] exp_rd = 32'h0;

  function automatic int idx(logic [31:0] a);
    return (a >= IOB) ? 256 + int'(a[7:0]) : int'(a[7:0]);
  endfunction

  function automatic int nb(logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ext(logic [31:0] v,
                                      logic [1:0] s, logic z);
    if (s == 2'd0)
      return z ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (s == 2'd1)
      return z ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a,
                                         logic [1:0] s, logic z);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nb(s); i++)
      v[8*i +: 8] = smem[idx(a + 32'(i))];
    return ext(v, s, z);
  endfunction

  function automatic logic [31:0] ref_ld(logic [31:0] a,
                                         logic [1:0] s, logic z);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nb(s); i++)
      v[8*i +: 8] = rmem[idx(a + 32'(i))];
    return ext(v, s, z);
  endfunction

  function automatic int exp_lat(logic we, logic [31:0] a,
                                 logic [1:0] s);
    logic mis;
    if (s == 2'd3) return 1;
    mis = (a < IOB) && ((s == 2'd1 && a[1:0] == 2'd3) ||
                        (s == 2'd2 && a[1:0] != 2'd0));
    if (we) return mis ? nb(s) : 1;
    return mis ? 3 : 2;
  endfunction

  task automatic poke(logic [31:0] a, logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      smem[idx(a + 32'(i))] = w[8*i +: 8];
      rmem[idx(a + 32'(i))] = w[8*i +: 8];
    end
  endtask

  // byte-addressed data memory with one-cycle read latency
  always @(posedge CLK) begin
    if (MEM_WRITE2)
      for (int i = 0; i < nb(MEM_SIZE); i++)
        smem[idx(MEM_ADDR2 + 32'(i))] = MEM_DIN2[8*i +: 8];
    if (MEM_READ2)
      MEM_DOUT2 <= mem_rd(MEM_ADDR2, MEM_SIZE, MEM_SIGN);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic run_op(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s,
                        input logic z, input bit b2b,
                        output int lat, output logic err,
                        output int bm);
    if (!b2b) @(negedge CLK);
    WE = we; ADDR = a; WDATA = d; SIZE = s; SIGN = z;
    REQ = 1'b1;
    lg_c.delete(); lg_w.delete(); lg_a.delete();
    lg_d.delete(); lg_s.delete();
    lat = -1; err = 1'bx; bm = 0;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0 && DONE) begin
        lat = c; err = ERR;
        break;
      end
      if (MEM_READ2 || MEM_WRITE2) begin
        lg_c.push_back(c); lg_w.push_back(MEM_WRITE2);
        lg_a.push_back(MEM_ADDR2); lg_d.push_back(MEM_DIN2);
        lg_s.push_back(MEM_SIZE);
      end
      if (BUSY) bm |= (1 << c);
      @(posedge CLK);
      #1 REQ = 1'b0;
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic xact(input string tag, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic z,
                      input bit b2b, output int bm);
    int lat;
    logic err;
    logic [31:0] ev;
    int el;
    el = exp_lat(we, a, s);
    ev = ref_ld(a, s, z);
    run_op(we, a, d, s, z, b2b, lat, err, bm);
    chk({tag, "/lat"}, 32'(lat), 32'(el));
    chk({tag, "/err"}, {31'h0, err}, {31'h0, s == 2'd3});
    if (!we && s != 2'd3) exp_rd = ev;
    chk({tag, "/rdata"}, RDATA, exp_rd);
    if (we && s != 2'd3)
      for (int i = 0; i < nb(s); i++)
        rmem[idx(a + 32'(i))] = d[8*i +: 8];
  endtask

  initial begin
    int bm;
    logic [31:0] a;
    RST = 1'b1; REQ = 1'b0; WE = 1'b0; SIGN = 1'b0;
    ADDR = 32'h0; WDATA = 32'h0; SIZE = 2'd0;
    for (int i = 0; i < 512; i++) begin
      smem[i] = 8'($urandom);
      rmem[i] = smem[i];
    end
    poke(32'h100, 32'h44332211);
    poke(32'h104, 32'h88776655);
    poke(32'h108, 32'h000000F0);
    poke(IOB + 32'h2, 32'hCAFEF00D);

    repeat (2) @(negedge CLK);
    #1;
    chk("rst/busy", {31'h0, BUSY}, 32'h0);
    chk("rst/done", {31'h0, DONE}, 32'h0);
    chk("rst/err", {31'h0, ERR}, 32'h0);
    chk("rst/rdata", RDATA, 32'h0);
    chk("rst/strb", {30'h0, MEM_READ2, MEM_WRITE2}, 32'h0);
    RST = 1'b0;

    // 1: aligned word load
    xact("t1", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0, bm);
    chk("t1/val", RDATA, 32'h44332211);
    chk("t1/nops", 32'(lg_a.size()), 32'd1);
    chk("t1/addr", lg_a[0], 32'h100);
    chk("t1/busy", 32'(bm), 32'h2);

    // 2: misaligned word load
    xact("t2", 1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 1'b0, bm);
    chk("t2/val", RDATA, 32'h66554433);
    chk("t2/nops", 32'(lg_a.size()), 32'd2);
    chk("t2/a0", lg_a[0], 32'h100);
    chk("t2/a1", lg_a[1], 32'h104);
    chk("t2/c1", 32'(lg_c[1]), 32'd1);

    // 3: misaligned halfword, both extensions
    xact("t3s", 1'b0, 32'h107, 32'h0, 2'd1, 1'b0, 1'b0, bm);
    chk("t3s/val", RDATA, 32'hFFFFF088);
    xact("t3z", 1'b0, 32'h107, 32'h0, 2'd1, 1'b1, 1'b0, bm);
    chk("t3z/val", RDATA, 32'h0000F088);

    // 4: misaligned word store as four byte stores
    xact("t4", 1'b1, 32'h101, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, bm);
    chk("t4/nops", 32'(lg_a.size()), 32'd4);
    for (int k = 0; k < 4 && k < lg_a.size(); k++) begin
      a = 32'hDEADBEEF;
      chk("t4/wa", lg_a[k], 32'h101 + 32'(k));
      chk("t4/wd", lg_d[k], {24'h0, a[8*k +: 8]});
      chk("t4/ws", {30'h0, lg_s[k]}, 32'h0);
    end
    xact("t4r0", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0, bm);
    chk("t4r0/val", RDATA, 32'hADBEEF11);
    xact("t4r1", 1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 1'b0, bm);
    chk("t4r1/val", RDATA, 32'h887766DE);

    // 5: illegal size and IO pass-through
    xact("t5e", 1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 1'b0, bm);
    chk("t5e/nops", 32'(lg_a.size()), 32'd0);
    chk("t5e/val", RDATA, 32'h887766DE);
    xact("t5io", 1'b0, IOB + 32'h2, 32'h0, 2'd2, 1'b0, 1'b0, bm);
    chk("t5io/val", RDATA, 32'hCAFEF00D);
    chk("t5io/nops", 32'(lg_a.size()), 32'd1);
    chk("t5io/addr", lg_a[0], IOB + 32'h2);

    // 6: reset during RD_HI, then back-to-back store/load
    @(negedge CLK);
    WE = 1'b0; ADDR = 32'h102; SIZE = 2'd2; SIGN = 1'b0;
    REQ = 1'b1;
    @(posedge CLK);
    #1 REQ = 1'b0;
    chk("t6/busy_hi", {31'h0, BUSY}, 32'h1);
    chk("t6/rd_hi", {31'h0, MEM_READ2}, 32'h1);
    RST = 1'b1;
    #1;
    chk("t6/busy_rst", {31'h0, BUSY}, 32'h0);
    chk("t6/rd_rst", {31'h0, MEM_READ2}, 32'h0);
    chk("t6/done_rst", {31'h0, DONE}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      chk("t6/no_done", {31'h0, DONE}, 32'h0);
    end
    exp_rd = 32'h0;
    xact("t6w", 1'b1, 32'h104, 32'h88776655, 2'd2, 1'b0, 1'b0, bm);
    xact("t6r", 1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 1'b1, bm);
    chk("t6r/val", RDATA, 32'h88776655);

    // random traffic against the byte-level reference
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0)
        a = IOB + 32'($urandom_range(0, 240));
      else
        a = 32'h100 + 32'($urandom_range(0, 240));
      xact("rnd", 1'($urandom_range(0, 1)), a, $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), bm);
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'(4 * i);
      xact("sweep", 1'b0, a, 32'h0, 2'd2, 1'b0, 1'b0, bm);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
